// File: rtl/noc_pkg.sv
// Shared router constants: port count, direction-code width and direction codes.
package noc_pkg;

    localparam int unsigned N_PORTS = 5;
    localparam int unsigned DIR_W   = 3;

    localparam logic [DIR_W-1:0] DIR_LOCAL = 3'd0;
    localparam logic [DIR_W-1:0] DIR_NORTH = 3'd1;
    localparam logic [DIR_W-1:0] DIR_EAST  = 3'd2;
    localparam logic [DIR_W-1:0] DIR_SOUTH = 3'd3;
    localparam logic [DIR_W-1:0] DIR_WEST  = 3'd4;

    typedef enum logic {StIdle, StBusy} out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first requester after the pointer, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 5,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    int unsigned w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = (32'(i_ptr) + k) % N;
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output packet-lock switch allocator: round-robin lock on the head flit,
// held until the tail transfers.
module switch_allocator #(
    parameter int unsigned N_PORTS = noc_pkg::N_PORTS,
    parameter int unsigned DIR_W   = noc_pkg::DIR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORTS-1:0]       req_val,
    input  logic [N_PORTS*DIR_W-1:0] req_dir,
    input  logic [N_PORTS-1:0]       req_tail,
    input  logic [N_PORTS-1:0]       out_ready,
    output logic [N_PORTS-1:0]       grant,
    output logic [N_PORTS-1:0]       out_val,
    output logic [N_PORTS*DIR_W-1:0] out_sel,
    output logic                     dir_err
);

    noc_pkg::out_state_e r_state [N_PORTS];
    noc_pkg::out_state_e w_state_d [N_PORTS];
    logic [DIR_W-1:0]    r_owner [N_PORTS];
    logic [DIR_W-1:0]    w_owner_d [N_PORTS];
    logic [N_PORTS-1:0]  r_owner_oh [N_PORTS];
    logic [N_PORTS-1:0]  w_owner_oh_d [N_PORTS];
    logic [DIR_W-1:0]    r_ptr [N_PORTS];
    logic [DIR_W-1:0]    w_ptr_d [N_PORTS];
    logic                r_dir_err;

    logic [DIR_W-1:0]    w_dir [N_PORTS];
    logic [N_PORTS-1:0]  w_bad;
    logic [N_PORTS-1:0]  w_req [N_PORTS];
    logic [N_PORTS-1:0]  w_win_oh [N_PORTS];
    logic [DIR_W-1:0]    w_win_idx [N_PORTS];
    logic [N_PORTS-1:0]  w_win_any;
    logic [N_PORTS-1:0]  w_xfer;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        assign w_dir[g] = req_dir[g*DIR_W +: DIR_W];

        rr_arbiter #(
            .N (N_PORTS),
            .W (DIR_W)
        ) u_arb (
            .i_req (w_req[g]),
            .i_ptr (r_ptr[g]),
            .o_gnt (w_win_oh[g]),
            .o_idx (w_win_idx[g]),
            .o_any (w_win_any[g])
        );
    end

    // Inputs already holding a grant are masked so an input never owns two outputs.
    always_comb begin
        w_bad = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_bad[i] = req_val[i] && (w_dir[i] >= DIR_W'(N_PORTS));
        end
        for (int o = 0; o < N_PORTS; o++) begin
            w_req[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                w_req[o][i] = req_val[i] && (w_dir[i] == DIR_W'(o)) && !grant[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < N_PORTS; o++) begin
                r_state[o]    <= noc_pkg::StIdle;
                r_owner[o]    <= '0;
                r_owner_oh[o] <= '0;
                r_ptr[o]      <= DIR_W'(N_PORTS - 1);
            end
            r_dir_err <= 1'b0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                r_state[o]    <= w_state_d[o];
                r_owner[o]    <= w_owner_d[o];
                r_owner_oh[o] <= w_owner_oh_d[o];
                r_ptr[o]      <= w_ptr_d[o];
            end
            r_dir_err <= |w_bad;
        end
    end

    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            w_state_d[o]    = r_state[o];
            w_owner_d[o]    = r_owner[o];
            w_owner_oh_d[o] = r_owner_oh[o];
            w_ptr_d[o]      = r_ptr[o];
            unique case (r_state[o])
                noc_pkg::StIdle: begin
                    if (w_win_any[o]) begin
                        w_state_d[o]    = noc_pkg::StBusy;
                        w_owner_d[o]    = w_win_idx[o];
                        w_owner_oh_d[o] = w_win_oh[o];
                        w_ptr_d[o]      = w_win_idx[o];
                    end
                end
                noc_pkg::StBusy: begin
                    if (w_xfer[o] && req_tail[r_owner[o]]) begin
                        w_state_d[o] = noc_pkg::StIdle;
                    end
                end
                default: w_state_d[o] = noc_pkg::StIdle;
            endcase
        end
    end

    always_comb begin
        grant   = '0;
        out_val = '0;
        out_sel = '0;
        w_xfer  = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            if (r_state[o] == noc_pkg::StBusy) begin
                grant                      = grant | r_owner_oh[o];
                w_xfer[o]                  = req_val[r_owner[o]] && out_ready[o];
                out_val[o]                 = w_xfer[o];
                out_sel[o*DIR_W +: DIR_W]  = r_owner[o];
            end
        end
    end

    assign dir_err = r_dir_err;

endmodule
